// File: rtl/sub_pkg.sv
// Shared constants and FSM state type for the serial field-arithmetic blocks.
package sub_pkg;
  localparam int DATA_WIDTH = 448;
  localparam int LIMB_W     = 64;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic int num_limbs(input int size, input int limb);
    return (size + limb - 1) / limb;
  endfunction
endpackage

// File: rtl/sub_if.sv
// Start/operand/result handshake of the serial subtractor; SUB_BUSY_EN adds busy.
interface sub_if #(parameter int SIZE = sub_pkg::DATA_WIDTH);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE:0]   result;
  logic            done;
`ifdef SUB_BUSY_EN
  logic            busy;
  modport master (output start, a, b, input result, done, busy);
  modport slave  (input start, a, b, output result, done, busy);
`else
  modport master (output start, a, b, input result, done);
  modport slave  (input start, a, b, output result, done);
`endif
endinterface

// File: rtl/sub_limb.sv
// One limb of the subtractor: d = x - y - bin, borrow taken from the extra top bit.
module sub_limb #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] t;

  assign t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  assign d    = t[W-1:0];
  assign bout = t[W];
endmodule

// File: rtl/sub.sv
// Limb-serial wide subtractor: result = {borrow, a-b}, one LIMB per clock.
// Optional busy output is enabled by defining SUB_BUSY_EN.
module sub
  import sub_pkg::*;
#(
  parameter int SIZE = DATA_WIDTH,
  parameter int LIMB = LIMB_W
) (
  input  logic clk,
  input  logic rst,
  sub_if.slave bus
);
  localparam int NUM_LIMBS = num_limbs(SIZE, LIMB);
  localparam int PW        = NUM_LIMBS * LIMB;
  localparam int IW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LIMBS - 1);

  state_t state, state_nxt;
  logic   accept, last;

  logic [NUM_LIMBS-1:0][LIMB-1:0] a_q, b_q, diff_q, diff_nxt;
  logic [IW-1:0]  idx;
  logic           borrow;
  logic           done_q;
  logic [SIZE:0]  result_q;
  logic [LIMB-1:0] limb_d;
  logic           limb_bout;
  logic [PW:0]    padded;

  sub_limb #(.W(LIMB)) u_limb (
    .x    (a_q[idx]),
    .y    (b_q[idx]),
    .bin  (borrow),
    .d    (limb_d),
    .bout (limb_bout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (idx == LAST_IDX) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial differences build up in diff_q so result only moves on completion.
  always_comb begin
    diff_nxt      = diff_q;
    diff_nxt[idx] = limb_d;
    padded        = {limb_bout, diff_nxt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx      <= '0;
      borrow   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q    <= PW'(bus.a);
        b_q    <= PW'(bus.b);
        idx    <= '0;
        borrow <= 1'b0;
      end else if (state == RUN) begin
        diff_q <= diff_nxt;
        borrow <= limb_bout;
        idx    <= idx + IW'(1);
        if (last) result_q <= padded[SIZE:0];
      end
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
`ifdef SUB_BUSY_EN
  assign bus.busy   = (state == RUN);
`endif
endmodule

// File: tb/tb_sub.sv
// Scoreboard bench for sub: stimulus pushes expected results, a negedge monitor checks them.
module tb_sub;
  localparam int SIZE = 448;
  localparam int LAT  = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sub_if #(.SIZE(SIZE)) bus ();

  sub #(.SIZE(SIZE), .LIMB(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int run_acc = -100;
  logic [SIZE:0] exp_q[$];
  int            acc_q[$];
  bit            prev_done = 1'b0;

  // Monitor: every done pulse pops one expected result and its accept cycle.
  always @(negedge clk) begin
    logic [SIZE:0] e;
    int            a;
    if (rst && bus.done) begin
      done_seen++;
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high %0d cycles, want 1", 2);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        if (bus.result !== e) begin
          errors++;
          $display("FAIL result: got %h want %h", bus.result, e);
        end
        checks++;
        if (cyc - a != LAT) begin
          errors++;
          $display("FAIL latency: got %0d want %0d", cyc - a, LAT);
        end
      end
    end
`ifdef SUB_BUSY_EN
    begin
      logic bexp;
      bexp = (run_acc >= 0) && (cyc >= run_acc) && (cyc - run_acc < LAT);
      checks++;
      if (bus.busy !== bexp) begin
        errors++;
        $display("FAIL busy: got %b want %b at cycle %0d", bus.busy, bexp, cyc);
      end
    end
`endif
    prev_done = rst && bus.done;
  end

  // Called just after a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                       input logic [SIZE:0] ev, input bit track);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    if (track) begin
      exp_q.push_back(ev);
      acc_q.push_back(cyc + 1);
    end
    run_acc = cyc + 1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = av;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_seen < target && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_seen < target) begin
      errors++;
      checks++;
      $display("FAIL timeout: done count %0d want %0d", done_seen, target);
    end
  endtask

  task automatic run(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                     input logic [SIZE:0] ev);
    int t;
    t = done_seen + 1;
    issue(av, bv, ev, 1'b1);
    wait_done(t);
  endtask

  function automatic logic [SIZE-1:0] rnd();
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [SIZE-1:0] ones;
  logic [SIZE-1:0] ra, rb;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    ones      = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.result !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got result=%h done=%b want 0/0", bus.result, bus.done);
    end
    #1 rst = 1'b1;
    @(negedge clk); #1;

    run({4'h2, {111{4'hF}}}, {4'h1, {111{4'hF}}}, {1'b0, 4'h1, {111{4'h0}}});
    run({4'h1, {50{4'hF}}, 4'hE, {60{4'hF}}}, ones,
        {1'b1, 4'h1, {51{4'hF}}, {60{4'h0}}});
    run(ones, ones, '0);
    run(SIZE'(5), SIZE'(3), (SIZE+1)'(2));
    run(ones, SIZE'(1), {1'b0, {111{4'hF}}, 4'hE});
    run('0, {4'h1, {111{4'hF}}}, {1'b1, 4'hE, {110{4'h0}}, 4'h1});
    run(SIZE'(3), SIZE'(5), {1'b1, {111{4'hF}}, 4'hE});

    // Start during RUN must be ignored: exactly one done follows.
    begin
      int t;
      t = done_seen + 1;
      issue(SIZE'(100), SIZE'(1), (SIZE+1)'(99), 1'b1);
      repeat (2) @(negedge clk);
      #1 bus.start = 1'b1; bus.a = SIZE'(7); bus.b = SIZE'(9);
      @(negedge clk); #1 bus.start = 1'b0;
      wait_done(t);
      repeat (12) @(negedge clk);
      checks++;
      if (done_seen != t) begin
        errors++;
        $display("FAIL ignore_start: got %0d dones want %0d", done_seen, t);
      end
      #1;
    end

    // Reset mid-RUN: no done, result cleared.
    begin
      int t;
      t = done_seen;
      issue(ones, SIZE'(2), '0, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      run_acc = -100;
      @(negedge clk);
      checks++;
      if (bus.result !== '0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort: got result=%h done=%b want 0/0", bus.result, bus.done);
      end
      #1 rst = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (done_seen != t || bus.result !== '0) begin
        errors++;
        $display("FAIL abort_no_done: got dones=%0d result=%h want %0d/0", done_seen, bus.result, t);
      end
      #1;
    end

    // Random pairs issued back-to-back in each done cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = rnd();
      rb = (i % 10 == 0) ? ra : rnd();
      run(ra, rb, {1'b0, ra} - {1'b0, rb});
    end

    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
